game_clock_ctrl: RTL

Countdown controller for the puzzle game clock. It sequences the 100 ms timer by driving its enable, and consumes the resulting 100 ms pulses. It keeps an MM:SS BCD countdown for the seven-segment display path and flags expiry to the game FSM. It sits between the top-level button/switch logic and the 100 ms timer instance.

---
 rtl/game_clock_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/game_clock_ctrl.sv
// Countdown controller for the puzzle game clock: gates the 100 ms timer and
// counts an MM:SS BCD value down to 00:00, flagging expiry to the game FSM.
module game_clock_ctrl #(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_min_tens,
  input  logic [3:0] load_min_ones,
  input  logic       start,
  input  logic       pause,
  output logic       timer_enable,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       time_up
);

  localparam int FRAC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [FRAC_W-1:0] FRAC_MAX = FRAC_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t            state, stateNext;
  logic [FRAC_W-1:0] frac, fracNext;
  logic [15:0]       digits, digitsNext, digitsDec;

  function automatic logic [3:0] clampBcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // One-second BCD decrement of {min_tens, min_ones, sec_tens, sec_ones}.
  function automatic logic [15:0] decSecond(input logic [15:0] d);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = d;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign digits    = {min_tens, min_ones, sec_tens, sec_ones};
  assign digitsDec = decSecond(digits);

  always_comb begin
    stateNext  = state;
    fracNext   = frac;
    digitsNext = digits;
    if (load) begin
      stateNext  = IDLE;
      fracNext   = '0;
      digitsNext = {clampBcd(load_min_tens), clampBcd(load_min_ones), 8'h00};
    end else begin
      unique case (state)
        IDLE: begin
          if (!pause && start && (digits != 16'h0000)) stateNext = RUN;
        end
        RUN: begin
          if (pause) begin
            stateNext = PAUSE;
          end else if (tick) begin
            if (frac != FRAC_MAX) begin
              fracNext = frac + FRAC_W'(1);
            end else begin
              fracNext   = '0;
              digitsNext = digitsDec;
              if (digitsDec == 16'h0000) stateNext = EXPIRED;
            end
          end
        end
        PAUSE: begin
          if (!pause && start) stateNext = RUN;
        end
        EXPIRED: begin
          stateNext = EXPIRED;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      frac         <= '0;
      min_tens     <= 4'd0;
      min_ones     <= 4'd0;
      sec_tens     <= 4'd0;
      sec_ones     <= 4'd0;
      timer_enable <= 1'b0;
      running      <= 1'b0;
      expired      <= 1'b0;
      time_up      <= 1'b0;
    end else begin
      state                                   <= stateNext;
      frac                                    <= fracNext;
      {min_tens, min_ones, sec_tens, sec_ones} <= digitsNext;
      timer_enable                            <= (stateNext == RUN);
      running                                 <= (stateNext == RUN);
      expired                                 <= (stateNext == EXPIRED);
      time_up                                 <= (stateNext == EXPIRED) && (state != EXPIRED);
    end
  end

endmodule
